// File: rtl/vid_stream_meter_pkg.sv
// Shared types and constants for the video stream meter.
package vid_stream_meter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned SUM_WIDTH     = 32;
  localparam int unsigned ERR_BITS      = 3;

  localparam int unsigned ERR_WIDTH   = 0;
  localparam int unsigned ERR_OUTSIDE = 1;
  localparam int unsigned ERR_SAT     = 2;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

endpackage

// File: rtl/vid_stream_meter.sv
// Measures active width, height and pixel checksum of a DE/HS/VS video stream
// and publishes them, with sticky error flags, once per completed frame.
module vid_stream_meter
  import vid_stream_meter_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [CNT_WIDTH-1:0]   width_o,
  output logic [CNT_WIDTH-1:0]   height_o,
  output logic [SUM_WIDTH-1:0]   checksum_o,
  output logic [ERR_BITS-1:0]    err_o,
  output logic                   frame_done_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cntx, cntx_nxt;
  logic [CNT_WIDTH-1:0]   cnty, cnty_nxt;
  logic [CNT_WIDTH-1:0]   ref_w, ref_w_nxt;
  logic                   ref_vld, ref_vld_nxt;
  logic [SUM_WIDTH-1:0]   sum, sum_nxt;
  logic [ERR_BITS-1:0]    err, err_nxt;

  logic                   pub_c;
  logic [CNT_WIDTH-1:0]   pub_w_c;
  logic [CNT_WIDTH-1:0]   pub_h_c;
  logic [SUM_WIDTH-1:0]   pub_sum_c;
  logic [ERR_BITS-1:0]    pub_err_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_nxt;
  end

  // Next state and working datapath: close line, then start frame, then take the pixel.
  always_comb begin
    state_nxt   = state;
    cntx_nxt    = cntx;
    cnty_nxt    = cnty;
    ref_w_nxt   = ref_w;
    ref_vld_nxt = ref_vld;
    sum_nxt     = sum;
    err_nxt     = err;
    pub_c       = 1'b0;
    pub_w_c     = '0;
    pub_h_c     = '0;
    pub_sum_c   = '0;
    pub_err_c   = '0;

    if (state == ACTIVE && hs_i && cntx != '0) begin
      if (cnty == CNT_MAX) err_nxt[ERR_SAT] = 1'b1;
      else                 cnty_nxt = cnty + CNT_WIDTH'(1);
      if (!ref_vld) begin
        ref_w_nxt   = cntx;
        ref_vld_nxt = 1'b1;
      end else if (cntx != ref_w) begin
        err_nxt[ERR_WIDTH] = 1'b1;
      end
    end

    if (hs_i && vs_i) begin
      pub_c       = (state == ACTIVE);
      pub_w_c     = ref_w_nxt;
      pub_h_c     = cnty_nxt;
      pub_sum_c   = sum;
      pub_err_c   = err_nxt;
      state_nxt   = ACTIVE;
      cnty_nxt    = '0;
      ref_w_nxt   = '0;
      ref_vld_nxt = 1'b0;
      sum_nxt     = '0;
      // Out-of-frame errors seen while waiting belong to the first measured frame.
      if (state == ACTIVE) err_nxt = '0;
    end

    if (hs_i) cntx_nxt = '0;

    if (de_i) begin
      if (state_nxt == ACTIVE) begin
        if (cntx_nxt == CNT_MAX) err_nxt[ERR_SAT] = 1'b1;
        else                     cntx_nxt = cntx_nxt + CNT_WIDTH'(1);
        sum_nxt = sum_nxt + SUM_WIDTH'(di_i);
      end else begin
        err_nxt[ERR_OUTSIDE] = 1'b1;
      end
    end
  end

  // Working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntx    <= '0;
      cnty    <= '0;
      ref_w   <= '0;
      ref_vld <= 1'b0;
      sum     <= '0;
      err     <= '0;
    end else begin
      cntx    <= cntx_nxt;
      cnty    <= cnty_nxt;
      ref_w   <= ref_w_nxt;
      ref_vld <= ref_vld_nxt;
      sum     <= sum_nxt;
      err     <= err_nxt;
    end
  end

  // Published results, held until the next completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_o      <= '0;
      height_o     <= '0;
      checksum_o   <= '0;
      err_o        <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= pub_c;
      if (pub_c) begin
        width_o    <= pub_w_c;
        height_o   <= pub_h_c;
        checksum_o <= pub_sum_c;
        err_o      <= pub_err_c;
      end
    end
  end

endmodule

// File: doc/vid_stream_meter.md
VID_STREAM_METER -- requirements
Module: vid_stream_meter

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8, sets the pixel data width.
REQ-002 Parameter CNT_WIDTH, default 16, sets the width of the pixel and line counters.
REQ-003 Port clk, input, 1 bit, the only clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 Port di_i, input, PIXEL_WIDTH bits, pixel data; valid only when de_i=1.
REQ-006 Port de_i, input, 1 bit, data enable; one pixel per clk cycle with de_i=1, and idle cycles are allowed anywhere.
REQ-007 Port hs_i, input, 1 bit, one-cycle pulse marking the start of a line.
REQ-008 Port vs_i, input, 1 bit, one-cycle pulse marking the start of a frame; it is meaningful only when coincident with hs_i.
REQ-009 Port width_o, output, CNT_WIDTH bits, measured active pixels per line of the last completed frame.
REQ-010 Port height_o, output, CNT_WIDTH bits, measured active lines of the last completed frame.
REQ-011 Port checksum_o, output, 32 bits, sum of di_i over all de_i cycles of the last completed frame, wrapping modulo 2^32.
REQ-012 Port err_o, output, 3 bits: [0] line width mismatch, [1] de_i outside a frame, [2] counter saturation.
REQ-013 Port frame_done_o, output, 1 bit, one-cycle pulse that SHALL fire whenever the outputs width_o, height_o, checksum_o and err_o update.

Function
REQ-014 The FSM SHALL have two states: WAIT_FRAME (after reset) and ACTIVE.
REQ-015 In WAIT_FRAME, hs_i&vs_i SHALL clear all working counters and move the FSM to ACTIVE; hs_i without vs_i SHALL be ignored.
REQ-016 In WAIT_FRAME, de_i=1 SHALL set the sticky working bit err[1].
REQ-017 In ACTIVE, a de_i cycle SHALL increment the pixel counter cntx and add di_i, zero-extended, to the 32-bit working sum.
REQ-018 In ACTIVE, hs_i without vs_i SHALL close the current line; if cntx>0 the line SHALL be counted (cnty+1) and compared.
REQ-019 Lines with cntx=0 SHALL be neither counted nor compared.
REQ-020 The first counted line's cntx SHALL be latched as the reference width; any later counted line whose cntx differs SHALL set sticky err[0].
REQ-021 In ACTIVE, hs_i&vs_i SHALL first close the current line as in REQ-018, then publish the results.
REQ-022 Publishing SHALL register width_o = reference width, height_o = cnty, checksum_o = working sum, err_o = sticky bits.
REQ-023 Publishing SHALL pulse frame_done_o exactly one cycle after the hs_i&vs_i cycle, then clear the working state and remain in ACTIVE.
REQ-024 If de_i=1 in the same cycle as hs_i, that pixel SHALL belong to the NEW line and, if vs_i=1 as well, to the NEW frame.
REQ-025 cntx and cnty SHALL saturate at 2^CNT_WIDTH-1 and set sticky err[2]; they SHALL NOT wrap.
REQ-026 The frame in progress SHALL be reported only when the next hs_i&vs_i arrives; the first hs_i&vs_i after reset SHALL produce no frame_done_o.
REQ-027 Published outputs SHALL hold their values between frame_done_o pulses.
REQ-028 The block SHALL NOT backpressure its source; it is a pure sink.

Reset
REQ-029 rst=1 SHALL force, asynchronously, FSM=WAIT_FRAME, all counters, sum and sticky bits to 0, width_o=height_o=checksum_o=err_o=0 and frame_done_o=0.
REQ-030 Reset asserted mid-frame SHALL discard that frame; after release, measurement SHALL resume only at the next hs_i&vs_i.

Structure
REQ-031 Package vid_stream_meter_pkg SHALL hold the FSM state enum, the err_o bit index constants (ERR_WIDTH=0, ERR_OUTSIDE=1, ERR_SAT=2) and the default CNT_WIDTH.
REQ-032 The block SHALL be a single flat module; no sub-module is required.

Verification
REQ-033 Two frames of 2550x34, de continuous, 350 ns line gaps, followed by a third hs_i&vs_i -> two frame_done_o pulses, each with width_o=2550, height_o=34, err_o=0.
REQ-034 Frame of 4x2, di = (x+1) + 16*y, de on every 2nd cycle, followed by hs_i&vs_i -> width_o=4, height_o=2, checksum_o=84, err_o=0.
REQ-035 Frame of 2550x34 with line 5 carrying 2549 pixels -> frame_done_o with err_o=3'b001, width_o=2550, height_o=34.
REQ-036 de_i pulses before the first hs_i&vs_i after reset, then a clean 16x16 frame -> that frame reports err_o=3'b010 and width_o=16.
REQ-037 rst pulsed at line 10 of a 2550x34 frame -> all outputs read 0 and no frame_done_o occurs; the next two clean frames report 2550x34 on the second hs_i&vs_i only.
REQ-038 CNT_WIDTH=4 with a 20-pixel line -> width_o=15 and err_o[2]=1.
